// File: rtl/ping_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ping_sched_pkg
//  Description : Shared types and default parameters for the ping scheduler.
//                Contents:
//                  - ping_state_t : scheduler FSM state encoding
//                  - DEF_DATA_WIDTH / DEF_DLY_NUM / DEF_TIMEOUT : defaults
//                  - idx_width()  : width of an index into DLY_NUM entries
//  Revision    : 1.0 - initial release
// ============================================================================
package ping_sched_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DLY_NUM    = 3;
    localparam int DEF_TIMEOUT    = 65535;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_PING     = 3'd3,
        ST_MEASURE  = 3'd4,
        ST_REPORT   = 3'd5
    } ping_state_t;

    // An index register needs at least one bit even for a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ping_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ping_lat_counter
//  Description : Ping-to-pong latency counter with clear, enable, saturation
//                and timeout compare.
//  Ports       : clk        in   clock
//                reset_n    in   async active-low reset
//                clr        in   restart; count reads 1 on the next cycle,
//                                i.e. the first measurement cycle
//                en         in   advance by one (saturating)
//                count      out  DATA_WIDTH current latency
//                at_timeout out  count equals TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module ping_lat_counter
    import ping_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  at_timeout
);

    localparam logic [DATA_WIDTH-1:0] C_ONE     = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] C_MAX     = '1;
    localparam logic [DATA_WIDTH-1:0] C_TIMEOUT = DATA_WIDTH'(TIMEOUT);

    logic [DATA_WIDTH-1:0] r_count;

    // Clear loads 1 rather than 0: the edge leaving the ping cycle already
    // counts as the first cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= C_ONE;
        end else if (en && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count      = r_count;
    assign at_timeout = (r_count == C_TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/ping_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ping_scheduler
//  Description : Loads DLY_NUM delay words from a host stream to the antenna,
//                then for each entry issues a ping, measures the pong latency
//                (bounded by TIMEOUT) and reports it on a result stream.
//                Optional feature macro: PING_SCHED_STATS_EN enables min/max
//                latency tracking on stat_min/stat_max (tied to 0 otherwise).
//  Ports       : clk, reset_n                 clock, async active-low reset
//                start, abort                 run begin pulse, sync abort
//                s_tvalid/s_tready/s_tdata    host delay-word stream
//                ant_tvalid/ant_tdata         delay words to antenna
//                ant_ping/ant_pong/ant_ping_ready  antenna ping handshake
//                res_valid/res_ready/res_data/res_timeout  result stream
//                busy, done                   status
//                stat_min, stat_max           latency statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module ping_scheduler
    import ping_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DLY_NUM    = DEF_DLY_NUM,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  ant_tvalid,
    output logic [DATA_WIDTH-1:0] ant_tdata,
    output logic                  ant_ping,
    input  logic                  ant_pong,
    input  logic                  ant_ping_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_timeout,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] stat_min,
    output logic [DATA_WIDTH-1:0] stat_max
);

    localparam int                    IDX_W      = idx_width(DLY_NUM);
    localparam logic [IDX_W-1:0]      C_IDX_LAST = IDX_W'(DLY_NUM - 1);
    localparam logic [IDX_W-1:0]      C_IDX_ONE  = IDX_W'(1);
    localparam logic [DATA_WIDTH-1:0] C_TIMEOUT  = DATA_WIDTH'(TIMEOUT);

    ping_state_t           r_state;
    ping_state_t           w_next;
    logic [IDX_W-1:0]      r_idx;
    logic                  w_idx_last;
    logic                  w_s_hs;
    logic                  w_res_hs;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic [DATA_WIDTH-1:0] w_count;
    logic                  w_at_timeout;

    // ------------------------------------------------------------------------
    // Latency counter
    // ------------------------------------------------------------------------
    ping_lat_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_lat_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (w_cnt_clr),
        .en         (w_cnt_en),
        .count      (w_count),
        .at_timeout (w_at_timeout)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_idx_last = (r_idx == C_IDX_LAST);

    // ------------------------------------------------------------------------
    // FSM next state and state-decoded outputs.
    // The stream handshakes are masked during abort so the host never sees a
    // transfer accepted by a run that is being discarded.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        s_tready  = 1'b0;
        ant_ping  = 1'b0;
        res_valid = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                s_tready = !abort;
                if (s_tvalid && w_idx_last) w_next = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (ant_ping_ready) w_next = ST_PING;
            end
            ST_PING: begin
                ant_ping  = 1'b1;
                w_cnt_clr = 1'b1;
                w_next    = ST_MEASURE;
            end
            ST_MEASURE: begin
                w_cnt_en = 1'b1;
                if (ant_pong || w_at_timeout) w_next = ST_REPORT;
            end
            ST_REPORT: begin
                res_valid = !abort;
                if (res_ready) begin
                    w_next = (w_idx_last || res_timeout) ? ST_IDLE : ST_WAIT_RDY;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    assign w_s_hs   = s_tvalid && s_tready;
    assign w_res_hs = res_valid && res_ready;
    assign busy     = (r_state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Datapath: entry index, antenna word register, result register, done
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            ant_tvalid  <= 1'b0;
            ant_tdata   <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            r_idx       <= '0;
            ant_tvalid  <= 1'b0;
            ant_tdata   <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            done        <= 1'b0;
        end else begin
            ant_tvalid <= w_s_hs;
            done       <= 1'b0;
            if (w_s_hs) ant_tdata <= s_tdata;
            case (r_state)
                ST_IDLE: begin
                    if (start) r_idx <= '0;
                end
                ST_LOAD: begin
                    // The index doubles as the word count while loading and
                    // is rewound for the measurement phase.
                    if (w_s_hs) r_idx <= w_idx_last ? '0 : (r_idx + C_IDX_ONE);
                end
                ST_MEASURE: begin
                    // Pong has priority over a coincident timeout.
                    if (ant_pong) begin
                        res_data    <= w_count;
                        res_timeout <= 1'b0;
                    end else if (w_at_timeout) begin
                        res_data    <= C_TIMEOUT;
                        res_timeout <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (w_res_hs) begin
                        if (w_idx_last || res_timeout) begin
                            done  <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + C_IDX_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Latency statistics (non-timeout results since the last start)
    // ------------------------------------------------------------------------
`ifdef PING_SCHED_STATS_EN
    logic [DATA_WIDTH-1:0] r_stat_min;
    logic [DATA_WIDTH-1:0] r_stat_max;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_min <= '0;
            r_stat_max <= '0;
        end else if (abort) begin
            r_stat_min <= '0;
            r_stat_max <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stat_min <= '1;
            r_stat_max <= '0;
        end else if ((r_state == ST_MEASURE) && ant_pong) begin
            if (w_count < r_stat_min) r_stat_min <= w_count;
            if (w_count > r_stat_max) r_stat_max <= w_count;
        end
    end

    assign stat_min = r_stat_min;
    assign stat_max = r_stat_max;
`else
    assign stat_min = '0;
    assign stat_max = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ping_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ping_scheduler
//  Description : Self-checking bench for ping_scheduler (DATA_WIDTH=16,
//                DLY_NUM=3, TIMEOUT=50). An antenna model answers each ping
//                after a chosen latency; expected results come from a
//                latency list capped by TIMEOUT. Honours PING_SCHED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ping_scheduler;

    localparam int DW = 16;
    localparam int DN = 3;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          ant_tvalid;
    logic [DW-1:0] ant_tdata;
    logic          ant_ping;
    logic          ant_pong = 1'b0;
    logic          ant_ping_ready = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          res_timeout;
    logic          busy;
    logic          done;
    logic [DW-1:0] stat_min;
    logic [DW-1:0] stat_max;

    always #5 clk = ~clk;

    ping_scheduler #(
        .DATA_WIDTH (DW),
        .DLY_NUM    (DN),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .ant_tvalid     (ant_tvalid),
        .ant_tdata      (ant_tdata),
        .ant_ping       (ant_ping),
        .ant_pong       (ant_pong),
        .ant_ping_ready (ant_ping_ready),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_timeout    (res_timeout),
        .busy           (busy),
        .done           (done),
        .stat_min       (stat_min),
        .stat_max       (stat_max)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run description and reference expectations
    logic [DW-1:0] run_words [DN];
    int            run_lat   [DN];   // 0 = antenna never answers
    bit            run_gap;
    bit            run_stall;
    int            exp_n;
    int            exp_data  [DN];
    bit            exp_to    [DN];
    int            exp_min;
    int            exp_max;

    // Reference: each entry reports its latency, or TIMEOUT with the timeout
    // flag if the antenna is slower than TIMEOUT (or silent); a timeout ends
    // the run. Equal-to-TIMEOUT answers still count as answered.
    task automatic build_expect();
        exp_n   = 0;
        exp_min = (1 << DW) - 1;
        exp_max = 0;
        for (int i = 0; i < DN; i++) begin
            exp_n = i + 1;
            if (run_lat[i] == 0 || run_lat[i] > TO) begin
                exp_data[i] = TO;
                exp_to[i]   = 1'b1;
                break;
            end
            exp_data[i] = run_lat[i];
            exp_to[i]   = 1'b0;
            if (run_lat[i] < exp_min) exp_min = run_lat[i];
            if (run_lat[i] > exp_max) exp_max = run_lat[i];
        end
    endtask

    task automatic idle_inputs();
        start          = 1'b0;
        abort          = 1'b0;
        s_tvalid       = 1'b0;
        ant_pong       = 1'b0;
        ant_ping_ready = 1'b0;
        res_ready      = 1'b0;
    endtask

    task automatic do_run(input string name);
        int            ai = 0;
        int            wi = 0;
        int            ri = 0;
        int            pings = 0;
        int            acked = 0;
        int            pong_cnt = 0;
        int            stall = 0;
        int            cyc = 0;
        bit            awaiting = 1'b0;
        bit            prev_hs = 1'b0;
        bit            hold = 1'b0;
        bit            done_seen = 1'b0;
        bit            pong_now;
        logic [DW-1:0] hold_data = '0;
        logic          hold_to = 1'b0;
        build_expect();
        @(negedge clk);
        check({name, " idle busy"}, busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 3000) begin
            // ---- observe ----
            check({name, " ant_tvalid latency"}, ant_tvalid, prev_hs);
            if (ant_tvalid) begin
                check({name, " ant word count"}, ai < DN, 1);
                if (ai < DN) check({name, " ant_tdata"}, ant_tdata, run_words[ai]);
                ai++;
            end
            if (done) begin
                done_seen = 1'b1;
                check({name, " result count"}, ri, exp_n);
                check({name, " words forwarded"}, ai, DN);
                check({name, " busy at done"}, busy, 0);
                check({name, " res_valid at done"}, res_valid, 0);
                break;
            end
            check({name, " busy"}, busy, 1);
            pong_now = 1'b0;
            if (pong_cnt > 0) begin
                pong_cnt--;
                if (pong_cnt == 0) pong_now = 1'b1;
            end
            if (ant_ping) begin
                check({name, " ping only after report"}, pings, acked);
                check({name, " ping within run"}, pings < exp_n, 1);
                if (pings < DN && run_lat[pings] != 0) pong_cnt = run_lat[pings];
                pings++;
                awaiting = 1'b1;
            end
            if (hold) check({name, " res_valid held"}, res_valid, 1);
            if (res_valid) begin
                if (hold) begin
                    check({name, " res_data stable"}, res_data, hold_data);
                    check({name, " res_timeout stable"}, res_timeout, hold_to);
                end else begin
                    check({name, " result within run"}, ri < exp_n, 1);
                    if (ri < DN) begin
                        check({name, " res_data"}, res_data, exp_data[ri]);
                        check({name, " res_timeout"}, res_timeout, exp_to[ri]);
                    end
                    ri++;
                end
                if (run_stall && ri == 1 && stall < 10) begin
                    res_ready = 1'b0;
                    stall++;
                end else begin
                    res_ready = 1'($urandom_range(0, 1));
                end
                if (res_ready) begin
                    acked++;
                    awaiting = 1'b0;
                    hold     = 1'b0;
                end else begin
                    hold      = 1'b1;
                    hold_data = res_data;
                    hold_to   = res_timeout;
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
                hold      = 1'b0;
            end
            // ---- drive ----
            if (pong_now) ant_pong = 1'b1;
            else if (!awaiting && pong_cnt == 0) ant_pong = ($urandom_range(0, 3) == 0);
            else ant_pong = 1'b0;
            ant_ping_ready = ($urandom_range(0, 2) == 0);
            start          = ($urandom_range(0, 7) == 0);
            if (wi < DN) begin
                s_tvalid = run_gap ? (cyc % 2 == 0) : 1'b1;
                s_tdata  = run_words[wi];
                prev_hs  = s_tvalid && s_tready;
                if (prev_hs) wi++;
            end else begin
                check({name, " s_tready after last word"}, s_tready, 0);
                s_tvalid = 1'b1;
                s_tdata  = DW'($urandom);
                prev_hs  = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        check({name, " done reached"}, done_seen, 1);
        idle_inputs();
        @(negedge clk);
        check({name, " done one cycle"}, done, 0);
        check({name, " idle after run"}, busy, 0);
`ifdef PING_SCHED_STATS_EN
        check({name, " stat_min"}, stat_min, exp_min);
        check({name, " stat_max"}, stat_max, exp_max);
`else
        check({name, " stat_min tied"}, stat_min, 0);
        check({name, " stat_max tied"}, stat_max, 0);
`endif
    endtask

    task automatic set_run(input int l0, input int l1, input int l2, input bit gap, input bit stl);
        run_lat[0] = l0;
        run_lat[1] = l1;
        run_lat[2] = l2;
        run_gap    = gap;
        run_stall  = stl;
        for (int i = 0; i < DN; i++) run_words[i] = DW'($urandom);
    endtask

    initial begin
        int  n;
        bit  quiet;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset s_tready", s_tready, 0);
        check("reset ant_tvalid", ant_tvalid, 0);
        check("reset ant_ping", ant_ping, 0);
        check("reset res_valid", res_valid, 0);
        check("reset res_data", res_data, 0);
        check("reset done", done, 0);
        check("reset stat_min", stat_min, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- directed runs ----------------
        set_run(5, 10, 20, 1'b0, 1'b0);
        run_words[0] = 16'd5; run_words[1] = 16'd10; run_words[2] = 16'd20;
        do_run("basic");

        set_run($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40), 1'b1, 1'b0);
        do_run("gapped");

        set_run(0, 5, 5, 1'b0, 1'b0);
        do_run("timeout");

        set_run($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30), 1'b0, 1'b1);
        do_run("stall");

        set_run(50, 51, 3, 1'b0, 1'b0);
        do_run("timeout edge");

        set_run(7, 3, 9, 1'b0, 1'b0);
        do_run("stats");

        // ---------------- random runs ----------------
        for (int r = 0; r < 8; r++) begin
            set_run($urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_run("random");
        end

        // ---------------- abort in MEASURE ----------------
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        s_tvalid = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < DN; c++) begin
            s_tdata = DW'(c);
            if (s_tready) n++;
            @(negedge clk);
        end
        s_tvalid       = 1'b0;
        ant_ping_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && !ant_ping; c++) @(negedge clk);
        check("abort: ping seen", ant_ping, 1);
        ant_ping_ready = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort res_valid", res_valid, 0);
        check("abort done", done, 0);
        check("abort res_data", res_data, 0);
        ant_pong  = 1'b1;
        res_ready = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            ant_pong = 1'b0;
            if (res_valid || done || busy) quiet = 1'b0;
        end
        check("abort stays idle", quiet, 1);
        idle_inputs();

        // ---------------- reset mid-LOAD ----------------
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 16'd7;
        @(negedge clk);
        check("rst: in LOAD", s_tready, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst async busy", busy, 0);
        check("rst async s_tready", s_tready, 0);
        check("rst async ant_tvalid", ant_tvalid, 0);
        s_tvalid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ant_ping_ready = 1'b1;
        res_ready      = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (res_valid || done || busy || ant_ping) quiet = 1'b0;
        end
        check("rst run discarded", quiet, 1);
        idle_inputs();

        // ---------------- clean run after reset ----------------
        set_run(4, 8, 12, 1'b0, 1'b0);
        do_run("post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/ping_scheduler.md
PING_SCHEDULER -- requirements
Module: ping_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of delay words and latency results.
REQ-002 SHALL have parameter DLY_NUM, default 3, the number of delay entries per run.
REQ-003 SHALL have parameter TIMEOUT, default 65535, the maximum cycles to wait for a pong.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports clk and reset_n, listed first.
REQ-005 clk  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-006 start  in  1  pulse that begins a run; abort  in  1  synchronous return to IDLE.
REQ-007 s_tvalid/s_tready/s_tdata  in/out/in  1/1/DATA_WIDTH  host delay-word stream.
REQ-008 ant_tvalid/ant_tdata  out  1/DATA_WIDTH  delay words to the antenna.
REQ-009 ant_ping  out  1; ant_pong  in  1; ant_ping_ready  in  1  antenna ping handshake.
REQ-010 res_valid/res_ready/res_data/res_timeout  out/in/out/out  1/1/DATA_WIDTH/1  latency result stream.
REQ-011 busy  out  1  high when not IDLE; done  out  1  one-cycle pulse at the end of a run.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, WAIT_RDY, PING, MEASURE, REPORT.
REQ-013 IDLE: start=1 -> LOAD, idx=0; start is ignored in every other state.
REQ-014 LOAD: s_tready=1; each s_tvalid&&s_tready handshake drives ant_tvalid=1 and ant_tdata=s_tdata on the next cycle (1-cycle latency, registered).
REQ-015 LOAD: after the DLY_NUM-th handshake -> WAIT_RDY with idx=0; s_tready=0 in the same cycle as the transition.
REQ-016 WAIT_RDY: ant_ping_ready=1 -> PING; wait is unbounded.
REQ-017 PING: ant_ping=1 for exactly one cycle; latency counter cleared -> MEASURE.
REQ-018 MEASURE: counter starts at 1 in the first MEASURE cycle and increments per cycle; saturates at 2^DATA_WIDTH-1.
REQ-019 MEASURE with ant_pong=1: res_data=counter, res_timeout=0 -> REPORT.
REQ-020 MEASURE with counter==TIMEOUT and no pong: res_data=TIMEOUT, res_timeout=1 -> REPORT.
REQ-021 Pong and timeout in the same cycle: pong wins.
REQ-022 REPORT: res_valid=1, res_data and res_timeout stable until res_ready=1.
REQ-023 REPORT on handshake: if idx==DLY_NUM-1 or res_timeout=1 -> IDLE with done=1 for one cycle; otherwise idx++ -> WAIT_RDY.
REQ-024 ant_pong outside MEASURE SHALL be ignored.
REQ-025 abort=1 in any state -> IDLE on the next edge, all outputs to reset values, no done pulse; abort beats start.

Reset
REQ-026 reset_n=0 SHALL force IDLE asynchronously; all outputs are 0 and counters/idx are 0.
REQ-027 Assertion mid-run SHALL discard the run; no partial result is emitted after release.

Configuration
REQ-028 Macro PING_SCHED_STATS_EN defined: outputs stat_min and stat_max (DATA_WIDTH) track the minimum and maximum of non-timeout res_data since the last start.
REQ-029 PING_SCHED_STATS_EN defined: stat_min resets to all-ones and stat_max to 0 on start.
REQ-030 PING_SCHED_STATS_EN undefined: stat_min and stat_max are present, tied to 0, with no stats logic.

Structure
REQ-031 Package ping_sched_pkg SHALL hold the state enum type and the default DATA_WIDTH/DLY_NUM/TIMEOUT localparams.
REQ-032 The latency counter (clear, enable, saturate, timeout compare) SHALL be the sub-module ping_lat_counter.

Verification
REQ-033 start, then words 5,10,20 with the model answering each ping after d cycles -> ant_tdata 5,10,20 in order; res_data 5,10,20, res_timeout=0; one done pulse.
REQ-034 s_tvalid gapped every other cycle -> exactly 3 ant_tvalid pulses; s_tready=0 after the third.
REQ-035 TIMEOUT=50 with the model never ponging -> res_data=50, res_timeout=1, done, return to IDLE after the first entry.
REQ-036 res_ready held 0 for 10 cycles in REPORT -> res_valid and res_data stable; no new ant_ping.
REQ-037 abort in MEASURE, and separately reset_n low mid-LOAD -> IDLE, busy=0, no res_valid, no done.
REQ-038 PING_SCHED_STATS_EN defined with latencies 7,3,9 -> stat_min=3, stat_max=9.
